ps2_scancode_decoder: RTL and testbench

Consumes raw scan-code bytes from the `ps2_keyboard` receiver FIFO and turns them into key events. It sits directly downstream of `ps2_keyboard` and upstream of `keyboard_display`.
- Owns the receiver pop handshake.
- Tracks set-2 prefixes (`F0` break, `E0` extended).
- Suppresses typematic repeats.
- Exposes the held key, an ASCII translation and a press counter.

---
 rtl/ps2_pkg.sv | 32 +++
 rtl/ps2_ascii_rom.sv | 32 +++
 rtl/ps2_scancode_decoder.sv | 122 ++++++++++++
 tb/tb_ps2_scancode_decoder.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and scan-code constants for the PS/2 set-2 decoder.
// The optional ASCII lookup is enabled with the PS2_DECODE_ASCII_EN macro.
package ps2_pkg;

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_POP  = 2'd1,
    F_GAP  = 2'd2
  } fetch_state_t;

  typedef enum logic [1:0] {
    P_NORM    = 2'd0,
    P_BRK     = 2'd1,
    P_EXT     = 2'd2,
    P_EXT_BRK = 2'd3
  } prefix_state_t;

  localparam logic [7:0] PS2_BREAK  = 8'hF0;
  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_PAUSE  = 8'hE1;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_BAT_OK = 8'hAA;
  localparam logic [7:0] PS2_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_RESEND = 8'hFE;

  // Keyboard housekeeping bytes that carry no key information.
  function automatic logic is_discard(input logic [7:0] b);
    return (b == PS2_PAUSE) || (b == PS2_ACK) || (b == PS2_BAT_OK) ||
           (b == PS2_ECHO) || (b == PS2_RESEND);
  endfunction

endpackage

// File: rtl/ps2_ascii_rom.sv
// Set-2 scan code to ASCII lookup: lower-case letters, digits and space.
// Extended (E0-prefixed) codes always map to 0.
module ps2_ascii_rom (
  input  logic [7:0] code,
  input  logic       ext,
  output logic [7:0] ascii
);

  always_comb begin
    ascii = 8'h00;
    if (!ext) begin
      case (code)
        8'h1C: ascii = 8'h61; 8'h32: ascii = 8'h62; 8'h21: ascii = 8'h63;
        8'h23: ascii = 8'h64; 8'h24: ascii = 8'h65; 8'h2B: ascii = 8'h66;
        8'h34: ascii = 8'h67; 8'h33: ascii = 8'h68; 8'h43: ascii = 8'h69;
        8'h3B: ascii = 8'h6A; 8'h42: ascii = 8'h6B; 8'h4B: ascii = 8'h6C;
        8'h3A: ascii = 8'h6D; 8'h31: ascii = 8'h6E; 8'h44: ascii = 8'h6F;
        8'h4D: ascii = 8'h70; 8'h15: ascii = 8'h71; 8'h2D: ascii = 8'h72;
        8'h1B: ascii = 8'h73; 8'h2C: ascii = 8'h74; 8'h3C: ascii = 8'h75;
        8'h2A: ascii = 8'h76; 8'h1D: ascii = 8'h77; 8'h22: ascii = 8'h78;
        8'h35: ascii = 8'h79; 8'h1A: ascii = 8'h7A;
        8'h45: ascii = 8'h30; 8'h16: ascii = 8'h31; 8'h1E: ascii = 8'h32;
        8'h26: ascii = 8'h33; 8'h25: ascii = 8'h34; 8'h2E: ascii = 8'h35;
        8'h36: ascii = 8'h36; 8'h3D: ascii = 8'h37; 8'h3E: ascii = 8'h38;
        8'h46: ascii = 8'h39;
        8'h29: ascii = 8'h20;
        default: ascii = 8'h00;
      endcase
    end
  end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Pops bytes from the PS/2 receiver FIFO and decodes set-2 make/break/E0 sequences
// into key events. Define PS2_DECODE_ASCII_EN to drive key_ascii from the lookup.
module ps2_scancode_decoder
  import ps2_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       kbd_data,
  input  logic             kbd_ready,
  input  logic             kbd_overflow,
  output logic             kbd_nextdata_n,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic [7:0]       key_ascii,
  output logic             key_pressed,
  output logic             key_valid,
  output logic [CNT_W-1:0] key_cnt,
  output logic             err
);

  // Handshake: kbd_ready is the FIFO's valid for kbd_data; a byte is taken when
  // IDLE sees kbd_ready=1, and acknowledged by holding kbd_nextdata_n low for the
  // single POP cycle. GAP lets the receiver advance its head before the next look.
  fetch_state_t  fstate, fstate_n;
  prefix_state_t pstate, pstate_n;
  logic [7:0]       byte_q;
  logic [7:0]       code_n;
  logic             ext_n, pressed_n, valid_n;
  logic [CNT_W-1:0] cnt_n;
  logic             make_ext, brk_ext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fstate <= F_IDLE;
      byte_q <= 8'h00;
    end else begin
      fstate <= fstate_n;
      if (fstate == F_IDLE && kbd_ready) byte_q <= kbd_data;
    end
  end

  always_comb begin
    fstate_n = fstate;
    case (fstate)
      F_IDLE:  if (kbd_ready) fstate_n = F_POP;
      F_POP:   fstate_n = F_GAP;
      F_GAP:   fstate_n = F_IDLE;
      default: fstate_n = F_IDLE;
    endcase
  end

  assign kbd_nextdata_n = (fstate != F_POP);

  assign make_ext = (pstate == P_EXT);
  assign brk_ext  = (pstate == P_EXT_BRK);

  always_comb begin
    pstate_n  = pstate;
    code_n    = key_code;
    ext_n     = key_ext;
    pressed_n = key_pressed;
    valid_n   = 1'b0;
    cnt_n     = key_cnt;
    if (fstate == F_POP) begin
      if (byte_q == PS2_EXT) begin
        if (pstate == P_NORM)     pstate_n = P_EXT;
        else if (pstate == P_BRK) pstate_n = P_EXT_BRK;
      end else if (byte_q == PS2_BREAK) begin
        if (pstate == P_NORM)     pstate_n = P_BRK;
        else if (pstate == P_EXT) pstate_n = P_EXT_BRK;
      end else if (pstate == P_NORM && is_discard(byte_q)) begin
        pstate_n = pstate;
      end else if (pstate == P_NORM || pstate == P_EXT) begin
        // A make matching the held key is typematic auto-repeat.
        if (!(key_pressed && byte_q == key_code && make_ext == key_ext)) begin
          code_n    = byte_q;
          ext_n     = make_ext;
          pressed_n = 1'b1;
          valid_n   = 1'b1;
          cnt_n     = key_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        pstate_n = P_NORM;
      end else begin
        if (key_pressed && byte_q == key_code && brk_ext == key_ext) pressed_n = 1'b0;
        pstate_n = P_NORM;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pstate      <= P_NORM;
      key_code    <= 8'h00;
      key_ext     <= 1'b0;
      key_pressed <= 1'b0;
      key_valid   <= 1'b0;
      key_cnt     <= '0;
      err         <= 1'b0;
    end else begin
      pstate      <= pstate_n;
      key_code    <= code_n;
      key_ext     <= ext_n;
      key_pressed <= pressed_n;
      key_valid   <= valid_n;
      key_cnt     <= cnt_n;
      if (kbd_overflow) err <= 1'b1;
    end
  end

`ifdef PS2_DECODE_ASCII_EN
  ps2_ascii_rom u_ascii_rom (
    .code  (key_code),
    .ext   (key_ext),
    .ascii (key_ascii)
  );
`else
  assign key_ascii = 8'h00;
`endif

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench for ps2_scancode_decoder with a behavioural receiver FIFO model.
// Expected ASCII values follow the PS2_DECODE_ASCII_EN build setting.
module tb_ps2_scancode_decoder;

  localparam int CNT_W = 8;
`ifdef PS2_DECODE_ASCII_EN
  localparam bit ASCII_ON = 1'b1;
`else
  localparam bit ASCII_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [7:0]       kbd_data;
  logic             kbd_ready;
  logic             kbd_overflow = 1'b0;
  logic             kbd_nextdata_n;
  logic [7:0]       key_code;
  logic             key_ext;
  logic [7:0]       key_ascii;
  logic             key_pressed;
  logic             key_valid;
  logic [CNT_W-1:0] key_cnt;
  logic             err;

  int n_checks = 0;
  int n_err    = 0;

  // Receiver FIFO model and event counters
  logic [7:0] rx_q[$];
  int         pop_cyc[$];
  logic       pop_req = 1'b0;
  int         cyc = 0;
  int         pulse_total = 0;
  int         low_total = 0;
  int         pop_total = 0;

  assign kbd_ready = (rx_q.size() != 0);
  assign kbd_data  = (rx_q.size() != 0) ? rx_q[0] : 8'h00;

  ps2_scancode_decoder #(.CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .kbd_data       (kbd_data),
    .kbd_ready      (kbd_ready),
    .kbd_overflow   (kbd_overflow),
    .kbd_nextdata_n (kbd_nextdata_n),
    .key_code       (key_code),
    .key_ext        (key_ext),
    .key_ascii      (key_ascii),
    .key_pressed    (key_pressed),
    .key_valid      (key_valid),
    .key_cnt        (key_cnt),
    .err            (err)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    pop_req = !kbd_nextdata_n;
    if (!kbd_nextdata_n) low_total++;
    if (key_valid) pulse_total++;
  end

  always @(posedge clk) begin
    if (pop_req && rx_q.size() != 0) begin
      void'(rx_q.pop_front());
      pop_total++;
      pop_cyc.push_back(cyc);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic push(input logic [7:0] b);
    rx_q.push_back(b);
  endtask

  task automatic drain();
    for (int i = 0; i < 3000 && rx_q.size() != 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("drain_fifo_empty", rx_q.size(), 0);
  endtask

  int base_pulse, base_low, base_pop, seen;

  initial begin
    kbd_overflow = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_nextdata_n", kbd_nextdata_n, 1);
    check("rst_key_code", key_code, 0);
    check("rst_key_ext", key_ext, 0);
    check("rst_key_ascii", key_ascii, 0);
    check("rst_key_pressed", key_pressed, 0);
    check("rst_key_valid", key_valid, 0);
    check("rst_key_cnt", key_cnt, 0);
    check("rst_err", err, 0);
    rst = 1'b0;
    @(negedge clk);

    // 'a' press and release
    base_pulse = pulse_total;
    push(8'h1C);
    drain();
    check("a_pulse", pulse_total - base_pulse, 1);
    check("a_code", key_code, 8'h1C);
    check("a_ascii", key_ascii, ASCII_ON ? 8'h61 : 8'h00);
    check("a_pressed", key_pressed, 1);
    check("a_cnt", key_cnt, 1);
    push(8'hF0); push(8'h1C);
    drain();
    check("a_released", key_pressed, 0);
    check("a_code_kept", key_code, 8'h1C);
    check("a_pulse_total", pulse_total - base_pulse, 1);

    // 's' with typematic repeats
    base_pulse = pulse_total;
    push(8'h1B); push(8'h1B); push(8'h1B);
    drain();
    check("s_pulse", pulse_total - base_pulse, 1);
    check("s_ascii", key_ascii, ASCII_ON ? 8'h73 : 8'h00);
    check("s_cnt", key_cnt, 2);
    push(8'hF0);
    drain();
    check("s_held_after_f0", key_pressed, 1);
    push(8'h1B);
    drain();
    check("s_released", key_pressed, 0);

    // Extended right-arrow
    base_pulse = pulse_total;
    push(8'hE0); push(8'h75);
    drain();
    check("ext_flag", key_ext, 1);
    check("ext_code", key_code, 8'h75);
    check("ext_ascii", key_ascii, 0);
    check("ext_pressed", key_pressed, 1);
    check("ext_cnt", key_cnt, 3);
    push(8'hE0); push(8'hF0); push(8'h75);
    drain();
    check("ext_released", key_pressed, 0);
    check("ext_pulse", pulse_total - base_pulse, 1);

    // Back-to-back bytes with kbd_ready held high
    base_pulse = pulse_total;
    base_low   = low_total;
    base_pop   = pop_total;
    pop_cyc.delete();
    push(8'h16); push(8'h1E);
    drain();
    check("b2b_low_cycles", low_total - base_low, 2);
    check("b2b_pops", pop_total - base_pop, 2);
    check("b2b_spacing", (pop_cyc.size() == 2) ? (pop_cyc[1] - pop_cyc[0]) : 0, 3);
    check("b2b_pulses", pulse_total - base_pulse, 2);
    check("b2b_cnt", key_cnt, 5);
    check("b2b_code", key_code, 8'h1E);
    check("b2b_ascii", key_ascii, ASCII_ON ? 8'h32 : 8'h00);

    // Housekeeping byte in NORM is ignored
    push(8'hFA);
    drain();
    check("discard_cnt", key_cnt, 5);
    check("discard_code", key_code, 8'h1E);
    check("discard_pressed", key_pressed, 1);
    push(8'hF0); push(8'h1E);
    drain();
    check("two_released", key_pressed, 0);

    // Sticky overflow error
    kbd_overflow = 1'b1;
    @(negedge clk);
    kbd_overflow = 1'b0;
    check("err_set", err, 1);
    repeat (5) @(negedge clk);
    check("err_sticky", err, 1);

    // Counter wrap: 250 makes to reach 255, then one more
    for (int i = 0; i < 250; i++) push((i % 2) ? 8'h1B : 8'h1C);
    drain();
    check("cnt_255", key_cnt, 255);
    push(8'h1C);
    drain();
    check("cnt_wrap", key_cnt, 0);
    check("err_still_set", err, 1);

    // Reset while a latched byte is awaiting its pop
    push(8'h4D);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (!kbd_nextdata_n) begin
        seen = 1;
        break;
      end
    end
    check("midrst_pop_seen", seen, 1);
    rst = 1'b1;
    #1;
    check("midrst_nextdata_n", kbd_nextdata_n, 1);
    check("midrst_code", key_code, 0);
    check("midrst_pressed", key_pressed, 0);
    check("midrst_cnt", key_cnt, 0);
    check("midrst_err", err, 0);
    @(negedge clk);
    check("midrst_byte_kept", rx_q.size(), 1);
    base_pulse = pulse_total;
    rst = 1'b0;
    drain();
    check("midrst_pulse", pulse_total - base_pulse, 1);
    check("midrst_code_after", key_code, 8'h4D);
    check("midrst_cnt_after", key_cnt, 1);
    check("midrst_ascii", key_ascii, ASCII_ON ? 8'h70 : 8'h00);

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
